// File: rtl/pla_eval_pkg.sv
// Shared definitions for the programmable two-level AND/OR evaluator.
// Holds the derived width helpers, config select codes, AND-row field layout and the occupancy encoding.
// No logic of its own.
package pla_eval_pkg;

    // Config select codes: which plane a config write targets.
    localparam logic CFG_AND = 1'b0;
    localparam logic CFG_OR  = 1'b1;

    // AND-row layout inside cfg_data, expressed as multiples of N_IN:
    // care at [N_IN-1:0], pol at [2*N_IN-1:N_IN], en at bit 2*N_IN.
    localparam int AND_CARE_MUL = 0;
    localparam int AND_POL_MUL  = 1;
    localparam int AND_EN_MUL   = 2;

    // Pipeline occupancy, encoded as {s1_valid, out_valid}.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_S2    = 2'b01,
        OCC_S1    = 2'b10,
        OCC_FULL  = 2'b11
    } occ_e;

    // Config data must carry either a full AND row or a full OR mask.
    function automatic int pla_cw(input int n_in, input int n_term);
        int and_w;
        and_w = 2 * n_in + 1;
        return (and_w > n_term) ? and_w : n_term;
    endfunction

    // Address must reach the larger of the two planes; never narrower than one bit.
    function automatic int pla_aw(input int n_term, input int n_out);
        int rows;
        int bits;
        rows = (n_term > n_out) ? n_term : n_out;
        bits = $clog2(rows);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/pla_and_row.sv
// Single product-term evaluator: one AND-plane row applied to the input vector.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module pla_and_row #(
    parameter int N_IN = 41
) (
    input  logic [N_IN-1:0] in_data,
    input  logic [N_IN-1:0] care,
    input  logic [N_IN-1:0] pol,
    input  logic            en,
    output logic            term
);

    logic [N_IN-1:0] bit_ok;

    // A bit passes if it is don't-care or matches the programmed polarity; the row fires only when enabled.
    always_comb begin
        bit_ok = ~care | (in_data ~^ pol);
        term   = en & (&bit_ok);
    end

endmodule

// File: rtl/pla_eval_pipe.sv
// Programmable AND/OR plane evaluator, one input vector per cycle through two register stages.
// Latency: 2 cycles from input acceptance to out_valid when the output is not stalled.
// Backpressure: out_ready low in FULL stalls both stages; a pending config write holds in_ready low so the pipe drains.
module pla_eval_pipe
    import pla_eval_pkg::*;
#(
    parameter int N_IN   = 41,
    parameter int N_OUT  = 21,
    parameter int N_TERM = 32,
    localparam int CW    = pla_cw(N_IN, N_TERM),
    localparam int AW    = pla_aw(N_TERM, N_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_sel,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [CW-1:0]     cfg_data,
    output logic              cfg_err
);

    // Programmable planes.
    logic [N_IN-1:0]   care_q [N_TERM];
    logic [N_IN-1:0]   care_d [N_TERM];
    logic [N_IN-1:0]   pol_q  [N_TERM];
    logic [N_IN-1:0]   pol_d  [N_TERM];
    logic [N_TERM-1:0] en_q;
    logic [N_TERM-1:0] en_d;
    logic [N_TERM-1:0] mask_q [N_OUT];
    logic [N_TERM-1:0] mask_d [N_OUT];

    // Pipeline state.
    logic              s1_valid_q;
    logic              s1_valid_d;
    logic [N_TERM-1:0] term_q;
    logic [N_TERM-1:0] term_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [N_OUT-1:0]  out_data_q;
    logic [N_OUT-1:0]  out_data_d;
    logic              cfg_err_q;
    logic              cfg_err_d;

    // Combinational plane outputs and handshake terms.
    logic [N_TERM-1:0] term_w;
    logic [N_OUT-1:0]  or_w;
    occ_e              occ;
    logic              adv2;
    logic              in_fire;
    logic              cfg_fire;
    logic              and_hit;
    logic              or_hit;

    // AND plane: one evaluator per product term, fed straight from the input port.
    for (genvar t = 0; t < N_TERM; t++) begin : g_and
        pla_and_row #(
            .N_IN (N_IN)
        ) u_row (
            .in_data (in_data),
            .care    (care_q[t]),
            .pol     (pol_q[t]),
            .en      (en_q[t]),
            .term    (term_w[t])
        );
    end

    // OR plane: each output is the OR of the stage-1 terms selected by its mask.
    always_comb begin
        or_w = '0;
        for (int o = 0; o < N_OUT; o++) begin
            or_w[o] = |(term_q & mask_q[o]);
        end
    end

    // Occupancy and handshake: stage 2 advances when it is empty or being drained,
    // config only lands when the pipe is empty and always wins over a new input.
    always_comb begin
        occ       = occ_e'({s1_valid_q, out_valid_q});
        adv2      = s1_valid_q & (~out_valid_q | out_ready);
        in_ready  = ~cfg_valid & (~s1_valid_q | adv2);
        cfg_ready = (occ == OCC_EMPTY);
        in_fire   = in_valid & in_ready;
        cfg_fire  = cfg_valid & cfg_ready;
        and_hit   = (cfg_sel == CFG_AND) && (int'(cfg_addr) < N_TERM);
        or_hit    = (cfg_sel == CFG_OR)  && (int'(cfg_addr) < N_OUT);
    end

    // Config writes: update the addressed row; an address past the plane only raises the sticky error.
    always_comb begin
        care_d    = care_q;
        pol_d     = pol_q;
        en_d      = en_q;
        mask_d    = mask_q;
        cfg_err_d = cfg_err_q;
        for (int t = 0; t < N_TERM; t++) begin
            if (cfg_fire && and_hit && (int'(cfg_addr) == t)) begin
                care_d[t] = cfg_data[AND_CARE_MUL*N_IN +: N_IN];
                pol_d[t]  = cfg_data[AND_POL_MUL*N_IN +: N_IN];
                en_d[t]   = cfg_data[AND_EN_MUL*N_IN];
            end
        end
        for (int o = 0; o < N_OUT; o++) begin
            if (cfg_fire && or_hit && (int'(cfg_addr) == o)) begin
                mask_d[o] = cfg_data[N_TERM-1:0];
            end
        end
        if (cfg_fire && !and_hit && !or_hit) begin
            cfg_err_d = 1'b1;
        end
    end

    // Pipeline next state: stage 1 captures terms on acceptance, stage 2 captures the OR result on advance.
    always_comb begin
        s1_valid_d  = in_fire | (s1_valid_q & ~adv2);
        term_d      = in_fire ? term_w : term_q;
        out_valid_d = adv2 | (out_valid_q & ~out_ready);
        out_data_d  = adv2 ? or_w : out_data_q;
    end

    // State registers with synchronous reset; reset wipes both planes and discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_TERM; t++) begin
                care_q[t] <= '0;
                pol_q[t]  <= '0;
            end
            en_q <= '0;
            for (int o = 0; o < N_OUT; o++) begin
                mask_q[o] <= '0;
            end
            s1_valid_q  <= 1'b0;
            term_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            care_q      <= care_d;
            pol_q       <= pol_d;
            en_q        <= en_d;
            mask_q      <= mask_d;
            s1_valid_q  <= s1_valid_d;
            term_q      <= term_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pla_eval_pipe.sv
`timescale 1ns/1ps
module tb_pla_eval_pipe;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 2;
    localparam int N_TERM = 4;
    localparam int CW     = 9;
    localparam int AW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N_OUT-1:0]  out_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_sel;
    logic [AW-1:0]     cfg_addr;
    logic [CW-1:0]     cfg_data;
    logic              cfg_err;

    pla_eval_pipe #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .N_TERM (N_TERM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    // Reference model: plane contents as plain arrays, plus expected-output queue.
    logic [N_IN-1:0]   m_care [N_TERM];
    logic [N_IN-1:0]   m_pol  [N_TERM];
    logic              m_en   [N_TERM];
    logic [N_TERM-1:0] m_mask [N_OUT];
    logic              m_err;
    logic [N_OUT-1:0]  exp_q [$];

    typedef struct {
        logic [N_IN-1:0]  din;
        logic [N_OUT-1:0] dout;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int t = 0; t < N_TERM; t++) begin
            m_care[t] = '0;
            m_pol[t]  = '0;
            m_en[t]   = 1'b0;
        end
        for (int o = 0; o < N_OUT; o++) m_mask[o] = '0;
        m_err = 1'b0;
    endfunction

    // Output o is 1 when some enabled term in its mask matches x on every cared-about bit.
    function automatic logic [N_OUT-1:0] model_eval(input logic [N_IN-1:0] x);
        logic [N_OUT-1:0] r;
        r = '0;
        for (int o = 0; o < N_OUT; o++)
            for (int t = 0; t < N_TERM; t++)
                if (m_mask[o][t] && m_en[t] && (((x ^ m_pol[t]) & m_care[t]) == 0))
                    r[o] = 1'b1;
        return r;
    endfunction

    function automatic void model_cfg(input logic sel, input logic [AW-1:0] addr, input logic [CW-1:0] data);
        int a;
        a = int'(addr);
        if (!sel) begin
            if (a < N_TERM) begin
                m_care[a] = data[3:0];
                m_pol[a]  = data[7:4];
                m_en[a]   = data[8];
            end else m_err = 1'b1;
        end else begin
            if (a < N_OUT) m_mask[a] = data[3:0];
            else m_err = 1'b1;
        end
    endfunction

    // One clock: sample handshakes mid-cycle, then update the scoreboard after the edge.
    task automatic step();
        logic fi, fo, fc, hold;
        logic [N_OUT-1:0] od;
        logic [N_IN-1:0]  id;
        logic             csel;
        logic [AW-1:0]    cad;
        logic [CW-1:0]    cdat;
        #1;
        fi = in_valid && in_ready;
        fo = out_valid && out_ready;
        fc = cfg_valid && cfg_ready;
        hold = out_valid && !out_ready;
        od = out_data; id = in_data; csel = cfg_sel; cad = cfg_addr; cdat = cfg_data;
        @(posedge clk);
        #1;
        check("cfg_in_exclusive", 32'(fi && fc), 32'(0));
        if (fo) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) check("sb_data", 32'(od), 32'(exp_q.pop_front()));
        end
        if (hold) begin
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_data", 32'(out_data), 32'(od));
        end
        if (fi) begin
            exp_q.push_back(model_eval(id));
            n_acc++;
        end
        if (fc) model_cfg(csel, cad, cdat);
    endtask

    task automatic cfg_write(input logic sel, input logic [AW-1:0] addr, input logic [CW-1:0] data);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        cfg_valid = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        while (!done && n < 50) begin
            #1;
            check("cfg_blocks_in", 32'(in_ready), 32'(0));
            done = cfg_ready;
            if (done) check("cfg_lands_empty", 32'(out_valid), 32'(0));
            step();
            n++;
        end
        check("cfg_no_timeout", 32'(done), 32'(1));
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_clear();
    endtask

    task automatic drain(input int cycles);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        check("drain_empty", 32'(exp_q.size()), 32'(0));
        check("drain_idle", 32'(out_valid), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_OUT-1:0] held;
        logic [N_IN-1:0]  stall_v [3];
        logic             seen;
        logic             fcnow;

        // Table: out0 = (in[1:0]==01)|(in[3:2]==11), out1 = (in[3:2]==11)
        tbl[0] = '{4'b0000, 2'b00};
        tbl[1] = '{4'b0001, 2'b01};
        tbl[2] = '{4'b1101, 2'b11};
        tbl[3] = '{4'b1100, 2'b11};
        tbl[4] = '{4'b1000, 2'b00};
        tbl[5] = '{4'b0101, 2'b01};
        tbl[6] = '{4'b1111, 2'b11};
        tbl[7] = '{4'b0010, 2'b00};

        // Reset state and first-vector latency with empty planes.
        do_reset();
        #1;
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_cfg_err", 32'(cfg_err), 32'(0));
        check("rst_cfg_ready", 32'(cfg_ready), 32'(1));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        in_valid = 1'b1; in_data = 4'hF;
        step();
        in_valid = 1'b0;
        check("lat_plus1_valid", 32'(out_valid), 32'(0));
        step();
        check("lat_plus2_valid", 32'(out_valid), 32'(1));
        check("lat_plus2_data", 32'(out_data), 32'(2'b00));
        step();

        // Single term on out0, two back-to-back vectors.
        cfg_write(1'b0, 2'd0, 9'b1_0001_0011);
        cfg_write(1'b1, 2'd0, 9'h001);
        in_valid = 1'b1; in_data = 4'b1001;
        step();
        in_data = 4'b1011;
        step();
        in_valid = 1'b0;
        check("b2b_first_valid", 32'(out_valid), 32'(1));
        check("b2b_first_data", 32'(out_data), 32'(2'b01));
        step();
        check("b2b_second_valid", 32'(out_valid), 32'(1));
        check("b2b_second_data", 32'(out_data), 32'(2'b00));
        step();

        // Table-driven streaming at full rate.
        cfg_write(1'b0, 2'd1, 9'b1_1100_1100);
        cfg_write(1'b1, 2'd0, 9'h003);
        cfg_write(1'b1, 2'd1, 9'h00A);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin in_valid = 1'b1; in_data = tbl[i].din; end
            else in_valid = 1'b0;
            #1;
            if (i < 8) check("tbl_in_ready", 32'(in_ready), 32'(1));
            step();
            if (i >= 1) begin
                check("tbl_valid", 32'(out_valid), 32'(1));
                check("tbl_data", 32'(out_data), 32'(tbl[i-1].dout));
            end
        end
        drain(3);

        // Output stall: three offered, two accepted, then release.
        stall_v[0] = 4'b0001; stall_v[1] = 4'b1100; stall_v[2] = 4'b0101;
        out_ready = 1'b0; n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = stall_v[n_acc];
            step();
        end
        check("stall_accepted", 32'(n_acc), 32'(2));
        in_data = stall_v[n_acc];
        #1;
        check("stall_in_ready", 32'(in_ready), 32'(0));
        held = out_data;
        step(); step();
        check("stall_in_ready_late", 32'(in_ready), 32'(0));
        check("stall_data_stable", 32'(out_data), 32'(held));
        out_ready = 1'b1;
        #1;
        check("full_release_in_ready", 32'(in_ready), 32'(1));
        step();
        in_valid = 1'b0;
        check("stall_total_accepted", 32'(n_acc), 32'(3));
        drain(5);

        // Config request while FULL waits for the drain; next vector sees the new row.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'b0000; step();
        in_data = 4'b1000; step();
        in_data = 4'b0000;
        cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd3; cfg_data = 9'b1_0000_0000;
        #1;
        check("full_cfg_ready", 32'(cfg_ready), 32'(0));
        check("full_cfg_in_ready", 32'(in_ready), 32'(0));
        step();
        check("full_cfg_ready_held", 32'(cfg_ready), 32'(0));
        out_ready = 1'b1;
        cfg_write(1'b0, 2'd3, 9'b1_0000_0000);
        #1;
        check("post_cfg_in_ready", 32'(in_ready), 32'(1));
        step();
        in_valid = 1'b0;
        step();
        check("new_row_valid", 32'(out_valid), 32'(1));
        check("new_row_data", 32'(out_data), 32'(2'b10));
        drain(3);

        // Out-of-range OR addresses: handshake completes, rows untouched, sticky error.
        cfg_write(1'b1, 2'd3, 9'h1FF);
        check("oor_err_set", 32'(cfg_err), 32'(1));
        cfg_write(1'b1, 2'd2, 9'h0FF);
        check("oor_err_sticky", 32'(cfg_err), 32'(1));
        in_valid = 1'b1; in_data = 4'b0000;
        step();
        in_valid = 1'b0;
        step();
        check("oor_rows_kept", 32'(out_data), 32'(2'b10));
        drain(3);
        do_reset();
        #1;
        check("rst_clears_err", 32'(cfg_err), 32'(0));

        // Reset while a vector sits in stage 1: nothing comes out, planes are cleared.
        cfg_write(1'b0, 2'd3, 9'b1_0000_0000);
        cfg_write(1'b1, 2'd1, 9'h008);
        in_valid = 1'b1; in_data = 4'b0000;
        step();
        in_valid = 1'b0;
        check("s1_before_rst_valid", 32'(out_valid), 32'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        check("rst_s1_out_valid", 32'(out_valid), 32'(0));
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("rst_s1_no_stale", 32'(seen), 32'(0));
        in_valid = 1'b1; in_data = 4'b0000;
        step();
        in_valid = 1'b0;
        step();
        check("rst_rows_cleared_valid", 32'(out_valid), 32'(1));
        check("rst_rows_cleared_data", 32'(out_data), 32'(2'b00));
        drain(3);

        // Randomised traffic with interleaved config writes against the model.
        do_reset();
        for (int t = 0; t < N_TERM; t++) cfg_write(1'b0, AW'(t), CW'($urandom));
        for (int o = 0; o < N_OUT; o++) cfg_write(1'b1, AW'(o), CW'($urandom));
        for (int c = 0; c < 1500; c++) begin
            if (!cfg_valid && ($urandom_range(0, 49) == 0)) begin
                cfg_valid = 1'b1;
                cfg_sel   = 1'($urandom);
                cfg_addr  = AW'($urandom);
                cfg_data  = CW'($urandom);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = N_IN'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            fcnow = cfg_valid && cfg_ready;
            if (cfg_valid) check("rnd_cfg_blocks_in", 32'(in_ready), 32'(0));
            step();
            if (fcnow) cfg_valid = 1'b0;
        end
        cfg_valid = 1'b0;
        drain(6);
        check("rnd_cfg_err", 32'(cfg_err), 32'(m_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
